mips_multicycle_control: RTL and testbench
==========================================

Name: mips_multicycle_control

Overview:
- Moore-style main control FSM that sequences a multicycle variant of the team's MIPS datapath.
- The datapath shares one memory for instruction and data, and a single ALU, across cycles.
- The FSM decodes opcode/funct and drives every mux select, write enable and ALU op of that datapath, one step per cycle.
- It adds a memory-ready handshake with a bounded wait timeout that halts the core on a stuck bus.

Parameters:
- MEM_TIMEOUT, 16: max consecutive cycles waiting on mem_ready_i in one memory state before bus error; 0 disables the timeout.

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-low reset
- opcode_i  in  6  instruction[31:26] from the instruction register
- funct_i  in  6  instruction[5:0] from the instruction register
- mem_ready_i  in  1  memory completes the current access this cycle
- pc_write_o  out  1  unconditional PC load
- branch_eq_o / branch_ne_o  out  1 each  datapath loads PC if zero / not-zero
- i_or_d_o  out  1  memory address select: 0=PC, 1=ALUOut
- mem_read_o / mem_write_o  out  1 each  memory strobes
- ir_write_o  out  1  load instruction register
- reg_dst_o  out  2  write register select: 0=rt, 1=rd, 2=$31
- mem_to_reg_o  out  2  write data select: 0=ALUOut, 1=MDR, 2=PC
- reg_write_o  out  1  register file write enable
- alu_src_a_o  out  1  ALU A select: 0=PC, 1=A reg
- alu_src_b_o  out  2  ALU B select: 0=B reg, 1=4, 2=sign-ext imm, 3=sign-ext imm<<2
- alu_op_o  out  3  ALU op: 000 add, 001 sub, 010 funct, 011 or, 100 and, 101 lui
- pc_src_o  out  2  next-PC select: 0=ALU result, 1=ALUOut, 2=jump target, 3=A reg (jr)
- instr_done_o  out  1  one-cycle pulse on the last cycle of each instruction
- illegal_op_o  out  1  one-cycle pulse on an undecoded opcode
- bus_error_o  out  1  sticky; set on memory timeout
- state_o  out  4  current state, for debug

Behaviour:
- Reset:
  - State goes to FETCH and the wait counter to 0.
  - bus_error_o=0, instr_done_o=0, illegal_op_o=0.
  - All enables and selects are 0 unless the FETCH decode dictates otherwise; while reset is low, pc_write_o, ir_write_o and reg_write_o are forced to 0.
- Outputs are decoded from the state register only. The exceptions are the ready-qualified strobes noted per state.
- FETCH:
  - Drives mem_read=1, i_or_d=0, src_a=0, src_b=1, alu_op=add, pc_src=0.
  - ir_write and pc_write assert only when mem_ready_i=1; the FSM stays in FETCH while mem_ready_i=0.
  - Next state is DECODE.
- DECODE:
  - Drives src_a=0, src_b=3, alu_op=add (branch target into ALUOut).
  - Next state by opcode:
    - 000000 with funct 001000 → JR; other 000000 → RTYPE.
    - 100011/101011 → MEMADR.
    - 001000/001101/001100/001111 → IEXEC.
    - 000100/000101 → BRANCH.
    - 000010 → JUMP; 000011 → JAL.
    - Anything else → FETCH with illegal_op_o pulsed.
- MEMADR: src_a=1, src_b=2, alu_op=add. Next state is MEMRD for lw, MEMWR for sw.
- MEMRD: mem_read=1, i_or_d=1. Waits on ready, then goes to MEMWB.
- MEMWB: reg_dst=0, mem_to_reg=1, reg_write=1, instr_done. Next state FETCH.
- MEMWR: mem_write=1 and i_or_d=1, held until ready. On ready: instr_done, next state FETCH.
- RTYPE: src_a=1, src_b=0, alu_op=funct. Next state RWB.
- RWB: reg_dst=1, mem_to_reg=0, reg_write=1, instr_done. Next state FETCH.
- IEXEC: src_a=1, src_b=2, alu_op = add/or/and/lui for addi/ori/andi/lui. Next state IWB.
- IWB: reg_dst=0, reg_write=1, instr_done. Next state FETCH.
- BRANCH: src_a=1, src_b=0, alu_op=sub, pc_src=1, branch_eq (beq) or branch_ne (bne), instr_done. Next state FETCH.
- JUMP: pc_src=2, pc_write, instr_done. Next state FETCH.
- JAL: as JUMP, plus reg_dst=2, mem_to_reg=2, reg_write=1 (writes the PC+4 captured in FETCH).
- JR: pc_src=3, pc_write, instr_done. Next state FETCH.
- Cycle counts with zero wait states:
  - lw 5; R-type, I-type and sw 4.
  - beq/bne, j, jal and jr 3.
- Each wait cycle adds 1 cycle.
- Wait counter:
  - Increments each cycle in FETCH/MEMRD/MEMWR while mem_ready_i=0; clears on ready or on a state change.
  - When count reaches MEM_TIMEOUT (and MEM_TIMEOUT≠0), the FSM enters HALT and bus_error_o=1.
- HALT:
  - All enables are 0.
  - HALT is left only by reset.
- Reset mid-instruction: the access is abandoned and no partial register or PC write occurs after the reset edge.

Decomposition:
- Package mips_mc_pkg holds:
  - opcode/funct constants;
  - the 4-bit state encoding (FETCH=0 … HALT=14);
  - alu_op, pc_src, reg_dst and mem_to_reg codes.
- One sub-module, mc_wait_timer: parameterised saturating counter with clear, enable and expired output.

Test Plan:
- add (op 000000, funct 100000), ready always 1 → state sequence 0,1,RTYPE,RWB; reg_write=1 with reg_dst=1 only in cycle 4; one instr_done pulse.
- lw (100011) with mem_ready_i low 2 cycles in MEMRD → 7 cycles total; mem_read held for all 3 MEMRD cycles; reg_write with mem_to_reg=1 in the final cycle.
- FETCH with ready low 3 cycles → pc_write and ir_write asserted exactly once, on the ready cycle.
- jal (000011) → 3 cycles; final cycle shows pc_write=1, pc_src=2, reg_dst=2, mem_to_reg=2, reg_write=1. jr (funct 001000) → pc_src=3.
- opcode 111111 → illegal_op_o pulses in DECODE, FSM returns to FETCH; no reg_write or pc_write during DECODE.
- MEM_TIMEOUT=4 with ready stuck low in MEMWR → HALT after 4 cycles, bus_error_o=1 and stays 1; asserting reset low returns to FETCH with bus_error_o=0.

Source files
------------

// File: rtl/mips_mc_pkg.sv
// ============================================================================
// mips_mc_pkg : opcodes, state encoding and select codes for the multicycle
//               MIPS control FSM.                           Rev 1.0
// ============================================================================
`default_nettype none

package mips_mc_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_LUI   = 6'b001111;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;
  localparam logic [5:0] FN_JR    = 6'b001000;

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_RTYPE  = 4'd6,
    S_RWB    = 4'd7,
    S_IEXEC  = 4'd8,
    S_IWB    = 4'd9,
    S_BRANCH = 4'd10,
    S_JUMP   = 4'd11,
    S_JAL    = 4'd12,
    S_JR     = 4'd13,
    S_HALT   = 4'd14
  } state_t;

  typedef enum logic [2:0] {
    ALU_ADD   = 3'b000,
    ALU_SUB   = 3'b001,
    ALU_FUNCT = 3'b010,
    ALU_OR    = 3'b011,
    ALU_AND   = 3'b100,
    ALU_LUI   = 3'b101
  } alu_op_t;

  typedef enum logic [1:0] {
    PC_ALU    = 2'd0,
    PC_ALUOUT = 2'd1,
    PC_JUMP   = 2'd2,
    PC_JR     = 2'd3
  } pc_src_t;

  typedef enum logic [1:0] {
    RD_RT = 2'd0,
    RD_RD = 2'd1,
    RD_RA = 2'd2
  } reg_dst_t;

  typedef enum logic [1:0] {
    WB_ALUOUT = 2'd0,
    WB_MDR    = 2'd1,
    WB_PC     = 2'd2
  } mem_to_reg_t;

  typedef enum logic [1:0] {
    SRCB_B      = 2'd0,
    SRCB_FOUR   = 2'd1,
    SRCB_IMM    = 2'd2,
    SRCB_IMM_SH = 2'd3
  } src_b_t;

  function automatic logic is_mem_state(input state_t s);
    return (s == S_FETCH) || (s == S_MEMRD) || (s == S_MEMWR);
  endfunction

endpackage

`default_nettype wire

// File: rtl/mc_wait_timer.sv
// ============================================================================
// mc_wait_timer : saturating wait-cycle counter with clear, enable and an
//                 expiry flag on the MAX-th consecutive enabled cycle. Rev 1.0
// ============================================================================
`default_nettype none

module mc_wait_timer #(
  parameter int MAX = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  generate
    if (MAX == 0) begin : g_disabled
      assign expired = 1'b0;
    end else begin : g_enabled
      localparam int W = $clog2(MAX + 1);
      logic [W-1:0] count;

      always_ff @(posedge clk or negedge reset) begin
        if (!reset)
          count <= '0;
        else if (clear)
          count <= '0;
        else if (enable && (count != W'(MAX)))
          count <= count + 1'b1;
      end

      // Fires on the cycle whose increment would make count reach MAX.
      assign expired = enable && !clear && (count == W'(MAX - 1));
    end
  endgenerate

endmodule

`default_nettype wire

// File: rtl/mips_multicycle_control.sv
// ============================================================================
// mips_multicycle_control : Moore main-control FSM for the multicycle MIPS
//                           datapath with memory-ready wait and bus timeout.
//                                                           Rev 1.0
// ============================================================================
`default_nettype none

module mips_multicycle_control
  import mips_mc_pkg::*;
#(
  parameter int MEM_TIMEOUT = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] opcode_i,
  input  logic [5:0] funct_i,
  input  logic       mem_ready_i,
  output logic       pc_write_o,
  output logic       branch_eq_o,
  output logic       branch_ne_o,
  output logic       i_or_d_o,
  output logic       mem_read_o,
  output logic       mem_write_o,
  output logic       ir_write_o,
  output logic [1:0] reg_dst_o,
  output logic [1:0] mem_to_reg_o,
  output logic       reg_write_o,
  output logic       alu_src_a_o,
  output logic [1:0] alu_src_b_o,
  output logic [2:0] alu_op_o,
  output logic [1:0] pc_src_o,
  output logic       instr_done_o,
  output logic       illegal_op_o,
  output logic       bus_error_o,
  output logic [3:0] state_o
);

  state_t state, state_next;
  logic   pc_write, ir_write, reg_write;
  logic   wait_clear, wait_enable, wait_expired;
  logic   bus_error;

  // Leaving a memory state needs ready (or a timeout into HALT), so clearing
  // outside memory states covers the state-change case without a comb loop.
  assign wait_clear  = mem_ready_i || !is_mem_state(state);
  assign wait_enable = is_mem_state(state) && !mem_ready_i;

  mc_wait_timer #(
    .MAX (MEM_TIMEOUT)
  ) u_wait_timer (
    .clk     (clk),
    .reset   (reset),
    .clear   (wait_clear),
    .enable  (wait_enable),
    .expired (wait_expired)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= S_FETCH;
      bus_error <= 1'b0;
    end else begin
      state <= state_next;
      if (wait_expired)
        bus_error <= 1'b1;
    end
  end

  always_comb begin
    state_next   = state;
    pc_write     = 1'b0;
    ir_write     = 1'b0;
    reg_write    = 1'b0;
    branch_eq_o  = 1'b0;
    branch_ne_o  = 1'b0;
    i_or_d_o     = 1'b0;
    mem_read_o   = 1'b0;
    mem_write_o  = 1'b0;
    reg_dst_o    = RD_RT;
    mem_to_reg_o = WB_ALUOUT;
    alu_src_a_o  = 1'b0;
    alu_src_b_o  = SRCB_B;
    alu_op_o     = ALU_ADD;
    pc_src_o     = PC_ALU;
    instr_done_o = 1'b0;
    illegal_op_o = 1'b0;

    case (state)
      S_FETCH: begin
        mem_read_o  = 1'b1;
        alu_src_b_o = SRCB_FOUR;
        if (mem_ready_i) begin
          ir_write   = 1'b1;
          pc_write   = 1'b1;
          state_next = S_DECODE;
        end
      end
      S_DECODE: begin
        alu_src_b_o = SRCB_IMM_SH;
        case (opcode_i)
          OP_RTYPE:                         state_next = (funct_i == FN_JR) ? S_JR : S_RTYPE;
          OP_LW, OP_SW:                     state_next = S_MEMADR;
          OP_ADDI, OP_ORI, OP_ANDI, OP_LUI: state_next = S_IEXEC;
          OP_BEQ, OP_BNE:                   state_next = S_BRANCH;
          OP_J:                             state_next = S_JUMP;
          OP_JAL:                           state_next = S_JAL;
          default: begin
            state_next   = S_FETCH;
            illegal_op_o = 1'b1;
          end
        endcase
      end
      S_MEMADR: begin
        alu_src_a_o = 1'b1;
        alu_src_b_o = SRCB_IMM;
        state_next  = (opcode_i == OP_SW) ? S_MEMWR : S_MEMRD;
      end
      S_MEMRD: begin
        mem_read_o = 1'b1;
        i_or_d_o   = 1'b1;
        if (mem_ready_i)
          state_next = S_MEMWB;
      end
      S_MEMWB: begin
        mem_to_reg_o = WB_MDR;
        reg_write    = 1'b1;
        instr_done_o = 1'b1;
        state_next   = S_FETCH;
      end
      S_MEMWR: begin
        mem_write_o = 1'b1;
        i_or_d_o    = 1'b1;
        if (mem_ready_i) begin
          instr_done_o = 1'b1;
          state_next   = S_FETCH;
        end
      end
      S_RTYPE: begin
        alu_src_a_o = 1'b1;
        alu_op_o    = ALU_FUNCT;
        state_next  = S_RWB;
      end
      S_RWB: begin
        reg_dst_o    = RD_RD;
        reg_write    = 1'b1;
        instr_done_o = 1'b1;
        state_next   = S_FETCH;
      end
      S_IEXEC: begin
        alu_src_a_o = 1'b1;
        alu_src_b_o = SRCB_IMM;
        case (opcode_i)
          OP_ORI:  alu_op_o = ALU_OR;
          OP_ANDI: alu_op_o = ALU_AND;
          OP_LUI:  alu_op_o = ALU_LUI;
          default: alu_op_o = ALU_ADD;
        endcase
        state_next = S_IWB;
      end
      S_IWB: begin
        reg_write    = 1'b1;
        instr_done_o = 1'b1;
        state_next   = S_FETCH;
      end
      S_BRANCH: begin
        alu_src_a_o  = 1'b1;
        alu_op_o     = ALU_SUB;
        pc_src_o     = PC_ALUOUT;
        branch_eq_o  = (opcode_i == OP_BEQ);
        branch_ne_o  = (opcode_i == OP_BNE);
        instr_done_o = 1'b1;
        state_next   = S_FETCH;
      end
      S_JUMP: begin
        pc_src_o     = PC_JUMP;
        pc_write     = 1'b1;
        instr_done_o = 1'b1;
        state_next   = S_FETCH;
      end
      S_JAL: begin
        pc_src_o     = PC_JUMP;
        pc_write     = 1'b1;
        reg_dst_o    = RD_RA;
        mem_to_reg_o = WB_PC;
        reg_write    = 1'b1;
        instr_done_o = 1'b1;
        state_next   = S_FETCH;
      end
      S_JR: begin
        pc_src_o     = PC_JR;
        pc_write     = 1'b1;
        instr_done_o = 1'b1;
        state_next   = S_FETCH;
      end
      S_HALT: state_next = S_HALT;
      default: state_next = S_FETCH;
    endcase

    if (wait_expired)
      state_next = S_HALT;
  end

  // Architectural writes are held off for as long as reset is low.
  assign pc_write_o  = pc_write  && reset;
  assign ir_write_o  = ir_write  && reset;
  assign reg_write_o = reg_write && reset;
  assign bus_error_o = bus_error;
  assign state_o     = state;

endmodule

`default_nettype wire

// File: tb/tb_mips_multicycle_control.sv
// ============================================================================
// tb_mips_multicycle_control : directed per-cycle scoreboard bench for the
//                              multicycle MIPS control FSM.    Rev 1.0
// ============================================================================
`default_nettype none

module tb_mips_multicycle_control;

  typedef struct packed {
    logic [3:0] st;
    logic       pcw, beq, bne, iord, mr, mw, irw;
    logic [1:0] rdst, m2r;
    logic       rw, srca;
    logic [1:0] srcb;
    logic [2:0] aluop;
    logic [1:0] pcsrc;
    logic       done, ill, berr;
  } vec_t;

  typedef struct {
    string name;
    vec_t  v;
  } item_t;

  logic       clk;
  logic       reset;
  logic [5:0] opcode;
  logic [5:0] funct;
  logic       mem_ready;
  logic       pc_write, branch_eq, branch_ne, i_or_d, mem_read, mem_write, ir_write;
  logic [1:0] reg_dst, mem_to_reg;
  logic       reg_write, alu_src_a;
  logic [1:0] alu_src_b;
  logic [2:0] alu_op;
  logic [1:0] pc_src;
  logic       instr_done, illegal_op, bus_error;
  logic [3:0] state;

  item_t q[$];
  item_t mon_item;
  vec_t  act;
  vec_t  v;
  int    checks = 0;
  int    errors = 0;

  mips_multicycle_control #(
    .MEM_TIMEOUT (4)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .opcode_i     (opcode),
    .funct_i      (funct),
    .mem_ready_i  (mem_ready),
    .pc_write_o   (pc_write),
    .branch_eq_o  (branch_eq),
    .branch_ne_o  (branch_ne),
    .i_or_d_o     (i_or_d),
    .mem_read_o   (mem_read),
    .mem_write_o  (mem_write),
    .ir_write_o   (ir_write),
    .reg_dst_o    (reg_dst),
    .mem_to_reg_o (mem_to_reg),
    .reg_write_o  (reg_write),
    .alu_src_a_o  (alu_src_a),
    .alu_src_b_o  (alu_src_b),
    .alu_op_o     (alu_op),
    .pc_src_o     (pc_src),
    .instr_done_o (instr_done),
    .illegal_op_o (illegal_op),
    .bus_error_o  (bus_error),
    .state_o      (state)
  );

  assign act = {state, pc_write, branch_eq, branch_ne, i_or_d, mem_read, mem_write,
                ir_write, reg_dst, mem_to_reg, reg_write, alu_src_a, alu_src_b,
                alu_op, pc_src, instr_done, illegal_op, bus_error};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic vec_t blank(input logic [3:0] st);
    vec_t r;
    r    = '0;
    r.st = st;
    return r;
  endfunction

  function automatic vec_t fetch(input logic rdy);
    vec_t r;
    r      = blank(4'd0);
    r.mr   = 1'b1;
    r.srcb = 2'd1;
    r.pcw  = rdy;
    r.irw  = rdy;
    return r;
  endfunction

  function automatic vec_t decode(input logic ill);
    vec_t r;
    r      = blank(4'd1);
    r.srcb = 2'd3;
    r.ill  = ill;
    return r;
  endfunction

  // Queue this cycle's expectation, then advance to just after the next edge.
  task automatic step(input string name, input vec_t e);
    item_t it;
    it.name = name;
    it.v    = e;
    q.push_back(it);
    @(posedge clk);
    #1;
  endtask

  task automatic iexec(input string name, input logic [5:0] op, input logic [2:0] aop);
    vec_t e;
    opcode = op;
    step({name, "_f"}, fetch(1'b1));
    step({name, "_d"}, decode(1'b0));
    e = blank(4'd8); e.srca = 1'b1; e.srcb = 2'd2; e.aluop = aop;
    step({name, "_ex"}, e);
    e = blank(4'd9); e.rw = 1'b1; e.done = 1'b1;
    step({name, "_wb"}, e);
  endtask

  // Monitor: every cycle with a pending expectation is compared mid-cycle.
  initial begin
    forever begin
      @(negedge clk);
      if (q.size() > 0) begin
        mon_item = q.pop_front();
        checks++;
        if (act !== mon_item.v) begin
          errors++;
          $display("FAIL %s: got %h expected %h", mon_item.name, act, mon_item.v);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    reset     = 1'b0;
    mem_ready = 1'b1;
    opcode    = 6'h00;
    funct     = 6'h20;
    @(posedge clk);
    #1;
    step("rst0", fetch(1'b0));
    step("rst1", fetch(1'b0));
    reset = 1'b1;

    // add
    step("add_f", fetch(1'b1));
    step("add_d", decode(1'b0));
    v = blank(4'd6); v.srca = 1'b1; v.aluop = 3'b010;
    step("add_ex", v);
    v = blank(4'd7); v.rdst = 2'd1; v.rw = 1'b1; v.done = 1'b1;
    step("add_wb", v);

    // lw with two wait states in MEMRD
    opcode = 6'h23;
    step("lw_f", fetch(1'b1));
    step("lw_d", decode(1'b0));
    v = blank(4'd2); v.srca = 1'b1; v.srcb = 2'd2;
    step("lw_adr", v);
    mem_ready = 1'b0;
    v = blank(4'd3); v.iord = 1'b1; v.mr = 1'b1;
    step("lw_rd_w0", v);
    step("lw_rd_w1", v);
    mem_ready = 1'b1;
    step("lw_rd", v);
    v = blank(4'd4); v.m2r = 2'd1; v.rw = 1'b1; v.done = 1'b1;
    step("lw_wb", v);

    // sw with three fetch wait states and one MEMWR wait state
    opcode    = 6'h2b;
    mem_ready = 1'b0;
    step("sw_f_w0", fetch(1'b0));
    step("sw_f_w1", fetch(1'b0));
    step("sw_f_w2", fetch(1'b0));
    mem_ready = 1'b1;
    step("sw_f", fetch(1'b1));
    step("sw_d", decode(1'b0));
    v = blank(4'd2); v.srca = 1'b1; v.srcb = 2'd2;
    step("sw_adr", v);
    mem_ready = 1'b0;
    v = blank(4'd5); v.iord = 1'b1; v.mw = 1'b1;
    step("sw_wr_w0", v);
    mem_ready = 1'b1;
    v.done = 1'b1;
    step("sw_wr", v);

    // jal
    opcode = 6'h03;
    step("jal_f", fetch(1'b1));
    step("jal_d", decode(1'b0));
    v = blank(4'd12); v.pcw = 1'b1; v.pcsrc = 2'd2; v.rdst = 2'd2; v.m2r = 2'd2;
    v.rw = 1'b1; v.done = 1'b1;
    step("jal_x", v);

    // jr
    opcode = 6'h00; funct = 6'h08;
    step("jr_f", fetch(1'b1));
    step("jr_d", decode(1'b0));
    v = blank(4'd13); v.pcw = 1'b1; v.pcsrc = 2'd3; v.done = 1'b1;
    step("jr_x", v);

    // beq / bne
    opcode = 6'h04;
    step("beq_f", fetch(1'b1));
    step("beq_d", decode(1'b0));
    v = blank(4'd10); v.srca = 1'b1; v.aluop = 3'b001; v.pcsrc = 2'd1;
    v.beq = 1'b1; v.done = 1'b1;
    step("beq_x", v);
    opcode = 6'h05;
    step("bne_f", fetch(1'b1));
    step("bne_d", decode(1'b0));
    v.beq = 1'b0; v.bne = 1'b1;
    step("bne_x", v);

    // I-type ALU ops
    iexec("addi", 6'h08, 3'b000);
    iexec("ori",  6'h0d, 3'b011);
    iexec("andi", 6'h0c, 3'b100);
    iexec("lui",  6'h0f, 3'b101);

    // j
    opcode = 6'h02;
    step("j_f", fetch(1'b1));
    step("j_d", decode(1'b0));
    v = blank(4'd11); v.pcw = 1'b1; v.pcsrc = 2'd2; v.done = 1'b1;
    step("j_x", v);

    // illegal opcode returns straight to FETCH
    opcode = 6'h3f;
    step("ill_f", fetch(1'b1));
    step("ill_d", decode(1'b1));

    // sw stuck in MEMWR: times out after four wait cycles
    opcode = 6'h2b;
    step("ill_ret", fetch(1'b1));
    step("to_d", decode(1'b0));
    v = blank(4'd2); v.srca = 1'b1; v.srcb = 2'd2;
    step("to_adr", v);
    mem_ready = 1'b0;
    v = blank(4'd5); v.iord = 1'b1; v.mw = 1'b1;
    step("to_wr_w0", v);
    step("to_wr_w1", v);
    step("to_wr_w2", v);
    step("to_wr_w3", v);
    v = blank(4'd14); v.berr = 1'b1;
    step("halt0", v);
    mem_ready = 1'b1;
    step("halt1", v);
    step("halt2", v);

    // reset clears HALT and the sticky error
    reset = 1'b0;
    step("halt_rst", fetch(1'b0));
    reset  = 1'b1;
    opcode = 6'h02;
    step("post_f", fetch(1'b1));
    step("post_d", decode(1'b0));
    v = blank(4'd11); v.pcw = 1'b1; v.pcsrc = 2'd2; v.done = 1'b1;
    step("post_j", v);

    for (int i = 0; i < 5 && q.size() > 0; i++)
      @(negedge clk);
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending expectations, expected 0", q.size());
    end
    #2;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
